// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared types for the register-file write path: register
//               address and data words, the regfile write triple, and the
//               buffered multi-cycle write entry.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int CREG_NUM = 32;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

    // Regfile write interface triple
    typedef struct packed {
        logic       valid;
        creg_addr_t id;
        word_t      data;
    } rf_wr_t;

    // One buffered multi-cycle result
    typedef struct packed {
        creg_addr_t id;
        word_t      data;
    } wb_entry_t;

endpackage : rf_wb_arbiter_pkg
`default_nettype wire

// File: rtl/rf_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_wb_fifo
// Description : DEPTH-entry synchronous FIFO of {id, data} results from the
//               multi-cycle unit. Exports a per-slot valid vector and the
//               slot ids so the parent can build the pending-register mask.
// Ports       : clk, resetn      - clock, asynchronous active-low reset
//               i_push/i_push_entry - write an entry (caller guarantees !full)
//               i_pop            - drop the head (caller guarantees !empty)
//               o_head           - current head entry
//               o_full/o_empty   - occupancy flags from the registered count
//               o_entry_valid    - slot i currently holds a live entry
//               o_entry_id       - destination id stored in slot i
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         i_push,
    input  wb_entry_t                    i_push_entry,
    input  logic                         i_pop,
    output wb_entry_t                    o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic       [DEPTH-1:0]       o_entry_valid,
    output creg_addr_t [DEPTH-1:0]       o_entry_id
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] c_depth = (PW+1)'(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [DEPTH-1:0] r_vld;
    wb_entry_t        r_mem [DEPTH];

    // Pointers are exactly log2(DEPTH) wide, so natural overflow wraps them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; r_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == c_depth);
    assign o_entry_valid = r_vld;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_ids
            assign o_entry_id[gi] = r_mem[gi].id;
        end
    endgenerate

endmodule : rf_wb_arbiter_wb_fifo
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the single regfile write port between the in-order
//               writeback (port A, fixed priority, registered stall) and the
//               multi-cycle unit (port B, valid/ready, FIFO buffered with
//               same-cycle bypass when the FIFO is empty). A starvation guard
//               stalls A for one cycle so a waiting B head always drains.
// Ports       : clk, resetn               - clock, async active-low reset
//               a_valid/a_id/a_data      - writeback request
//               a_stall                  - registered hold for the writeback
//               b_valid/b_id/b_data      - multi-cycle result
//               b_ready                  - FIFO not full
//               rf_valid/rf_id/rf_data   - regfile write triple
//               pending                  - regs with a buffered B write
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                a_valid,
    input  logic [4:0]          a_id,
    input  logic [31:0]         a_data,
    output logic                a_stall,
    input  logic                b_valid,
    input  logic [4:0]          b_id,
    input  logic [31:0]         b_data,
    output logic                b_ready,
    output logic                rf_valid,
    output logic [4:0]          rf_id,
    output logic [31:0]         rf_data,
    output logic [CREG_NUM-1:0] pending
);

    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CW-1:0] c_starve_last = CW'(STARVE_MAX - 1);

    wb_entry_t              w_head;
    wb_entry_t              w_push_entry;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic       [DEPTH-1:0] w_entry_valid;
    creg_addr_t [DEPTH-1:0] w_entry_id;

    logic    w_a_win;
    logic    w_pop;
    logic    w_bypass;
    logic    w_push;
    rf_wr_t  w_wr;

    logic          r_a_stall;
    logic [CW-1:0] r_starve;

    rf_wb_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_entry_valid (w_entry_valid),
        .o_entry_id    (w_entry_id)
    );

    assign b_ready = ~w_fifo_full;
    assign a_stall = r_a_stall;

    // Write-port selection. Writes to r0 never claim the port; B results
    // for r0 are handshaken and silently dropped. resetn masks every source
    // so the port is idle while reset is held.
    always_comb begin
        w_a_win      = resetn & a_valid & ~r_a_stall & (a_id != '0);
        w_pop        = resetn & ~w_a_win & ~w_fifo_empty;
        w_bypass     = resetn & ~w_a_win & w_fifo_empty & b_valid & (b_id != '0);
        w_push       = b_valid & b_ready & (b_id != '0) & ~w_bypass;
        w_push_entry = '{id: b_id, data: b_data};

        w_wr = '0;
        if (w_a_win) begin
            w_wr = '{valid: 1'b1, id: a_id, data: a_data};
        end else if (w_pop) begin
            w_wr = '{valid: 1'b1, id: w_head.id, data: w_head.data};
        end else if (w_bypass) begin
            w_wr = '{valid: 1'b1, id: b_id, data: b_data};
        end
    end

    assign rf_valid = w_wr.valid;
    assign rf_id    = w_wr.id;
    assign rf_data  = w_wr.data;

    // Starvation guard: count consecutive cycles the B head loses to A.
    // On the last allowed loss, A is held off for exactly one cycle; that
    // cycle the head pops, which also clears the count. The count is
    // cleared at the trigger so it never needs a value past STARVE_MAX-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a_stall <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_a_stall <= 1'b0;
            if (w_fifo_empty || w_pop) begin
                r_starve <= '0;
            end else if (w_a_win) begin
                if (r_starve == c_starve_last) begin
                    r_a_stall <= 1'b1;
                    r_starve  <= '0;
                end else begin
                    r_starve <= r_starve + CW'(1);
                end
            end
        end
    end

    // Pending mask tracks live FIFO slots; duplicate ids keep the bit set
    // until the last copy drains.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                pending[w_entry_id[i]] = 1'b1;
            end
        end
    end

endmodule : rf_wb_arbiter
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers.
  - Port A: the in-order pipeline writeback. Fixed priority. No handshake except a registered stall.
  - Port B: the multi-cycle unit (mul/div). Valid/ready handshake, buffered in a small FIFO.
- Outputs the regfile write triple (valid, id, data) and a pending-register mask, so decode can detect hazards on buffered B writes.
- Sits between the writeback stage / multi-cycle unit and the regfile.

Parameters:
- DEPTH, 2, B-side FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, consecutive cycles a B head may lose to A before A is stalled.
- CREG_NUM, 32, architectural registers (from package).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- a_valid  in  1  pipeline writeback request this cycle.
- a_id  in  5  destination register.
- a_data  in  32  write data.
- a_stall  out  1  registered; pipeline must hold its writeback while high. a_valid is ignored that cycle.
- b_valid  in  1  multi-cycle result valid.
- b_id  in  5  destination register.
- b_data  in  32  result data.
- b_ready  out  1  FIFO can accept (not full). Combinational from registered count.
- rf_valid  out  1  regfile write enable.
- rf_id  out  5  regfile write index.
- rf_data  out  32  regfile write data.
- pending  out  CREG_NUM  bit i set while a B write to reg i is buffered and not yet written.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO emptied; starve counter = 0; a_stall = 0; pending = 0.
  - rf_valid = 0 combinationally, because all sources are empty or masked.
  - b_ready = 1 once reset deasserts.
  - An in-flight B handshake is lost; the multi-cycle unit is reset by the same signal.
- B acceptance: b_valid & b_ready pushes {b_id, b_data} at the clock edge.
  - Writes with b_id == 0 are accepted and consumed, never forwarded to the regfile, and never set pending.
- Same-cycle write selection, in priority order:
  1. a_valid & !a_stall & a_id != 0 → write A.
  2. Otherwise FIFO non-empty → write FIFO head and pop.
  3. Otherwise b_valid & b_id != 0 → bypass: write B directly. The push is suppressed, so B sees zero latency.
  4. Otherwise rf_valid = 0.
- A with a_id == 0 does not take the port; B may use it that cycle.
- Starvation guard:
  - The counter increments each cycle the FIFO is non-empty and A wins.
  - It clears on any pop or when the FIFO is empty.
  - When counter == STARVE_MAX-1 and A wins again, a_stall = 1 on the next cycle only.
  - In that cycle the head drains unconditionally and the counter clears. a_stall is never high two consecutive cycles.
- FIFO full: b_ready = 0. A full FIFO still pops when the port is free.
  - Push and pop in the same cycle are legal only when not full at the edge (ready is computed from registered count).
  - Pointers wrap modulo DEPTH.
- Pending mask:
  - pending[i] is the OR over valid FIFO entries of (id == i).
  - It is updated at the edge with push and pop.
  - Two entries with the same id keep the bit set until both drain.
- Ordering:
  - B writes retire in acceptance order.
  - A vs B ordering to the same register is not enforced here. Decode must stall any instruction writing or reading a register whose pending bit is set.

Decomposition:
- Package common: CREG_NUM, creg_addr_t (5 bits), word_t (32 bits), and a struct rf_wr_t {valid, id, data} shared with the regfile write interface.
- Sub-module wb_fifo: DEPTH-entry synchronous FIFO of {id, data} with push, pop, full, empty, and an entry-valid vector exported for the pending mask.

Test Plan:
- Bypass: FIFO empty, b_valid=1, b_id=5, b_data=0x1234, a_valid=0 → same cycle rf_valid=1, rf_id=5, rf_data=0x1234; pending stays 0.
- Priority: b_valid with id 3 accepted while a_valid=1 with id 7 for 3 cycles → rf writes id 7 each cycle; pending[3]=1; id 3 written in the first cycle a_valid=0, then pending[3] clears.
- Starvation: DEPTH=2, STARVE_MAX=4, a_valid held high, one B entry queued → a_stall=1 exactly in the 5th cycle after queuing; head written that cycle; a_stall=0 the next cycle.
- Full: push 2 B entries while A is continuously valid → b_ready=0. The first cycle A drops, one pop occurs and b_ready=1 the following cycle. Order preserved (ids 9 then 10).
- Reg zero: a_id=0 & a_valid=1 with b_id=4 queued → rf writes id 4. A b_id=0 push never produces rf_valid.
- Reset mid-operation: two entries queued, a_stall=1, resetn pulsed low asynchronously → immediately pending=0, a_stall=0, rf_valid=0; after release b_ready=1.
